// File: rtl/mouse_evq.sv
// Mouse event queue: snapshots the PS/2 receiver state word on every change while running
// and presents queued snapshots to the CPU through a two-word I/O window (event / status).
module mouse_evq #(
    parameter int DEPTH = 8,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [27:0] ms,
    input  logic        rd,
    input  logic        adr,
    output logic [31:0] dout
);
    localparam int AW = $clog2(DEPTH);

    logic [27:0]   last;
    logic [27:0]   mem [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [CW-1:0] count;
    logic          ovf;

    logic          push;
    logic          pop;
    logic          full;
    logic          valid;
    logic          coalesce;
    logic [AW-1:0] wr_addr;
    logic [31:0]   status;

    always_comb begin
        valid    = (count != '0);
        full     = (count == CW'(DEPTH));
        push     = ms[27] & (ms != last);
        pop      = rd & ~adr & valid;
        // A push into a full queue without a same-cycle pop replaces the newest entry.
        coalesce = push & ~pop & full;
        wr_addr  = coalesce ? (tail - AW'(1)) : tail;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last  <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            last <= ms;
            if (push && !coalesce)
                tail <= tail + AW'(1);
            if (pop)
                head <= head + AW'(1);
            if (push && !pop && !full)
                count <= count + CW'(1);
            else if (pop && !push)
                count <= count - CW'(1);
            if (coalesce)
                ovf <= 1'b1;
            else if (rd && adr)
                ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_addr] <= ms;
    end

    always_comb begin
        status         = '0;
        status[31]     = ovf;
        status[30]     = ms[27];
        status[CW-1:0] = count;
    end

    always_comb begin
        if (adr)
            dout = status;
        else
            dout = {valid, 3'b000, valid ? mem[head] : ms};
    end

endmodule

// File: tb/tb_mouse_evq.sv
// Directed testbench for mouse_evq (DEPTH = 8): inputs change 1 ns after each rising edge,
// outputs are checked 1 ns later, well away from the next edge.
module tb_mouse_evq;
    logic        clk = 1'b0;
    logic        rst;
    logic [27:0] ms;
    logic        rd;
    logic        adr;
    logic [31:0] dout;

    int n_cmp = 0;
    int n_err = 0;

    mouse_evq #(.DEPTH(8)) dut (
        .clk  (clk),
        .rst  (rst),
        .ms   (ms),
        .rd   (rd),
        .adr  (adr),
        .dout (dout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; ms = '0; rd = 1'b0; adr = 1'b0;
        tick();
        ms = 28'h8000005;
        #1;
        n_cmp++;
        if (dout !== 32'h08000005) begin
            n_err++; $display("FAIL reset_event: got %h want %h", dout, 32'h08000005);
        end
        adr = 1'b1;
        #1;
        n_cmp++;
        if (dout !== 32'h40000000) begin
            n_err++; $display("FAIL reset_status: got %h want %h", dout, 32'h40000000);
        end
        tick();
        rst = 1'b0; adr = 1'b0;
        tick();
        // first cycle after release: ms differs from reset last=0 -> pushed
        n_cmp++;
        if (dout !== 32'h88000005) begin
            n_err++; $display("FAIL first_push: got %h want %h", dout, 32'h88000005);
        end
        rd = 1'b1;
        #1;
        n_cmp++;
        if (dout !== 32'h88000005) begin
            n_err++; $display("FAIL first_read: got %h want %h", dout, 32'h88000005);
        end
        tick();
        rd = 1'b0;
        #1;
        n_cmp++;
        if (dout !== 32'h08000005) begin
            n_err++; $display("FAIL after_read_live: got %h want %h", dout, 32'h08000005);
        end
        adr = 1'b1;
        #1;
        n_cmp++;
        if (dout !== 32'h40000000) begin
            n_err++; $display("FAIL after_read_status: got %h want %h", dout, 32'h40000000);
        end
        adr = 1'b0;
    endtask

    task automatic test_run_gate();
        for (int i = 0; i < 10; i++) begin
            ms = {18'd0, 10'(i + 1)};
            tick();
        end
        adr = 1'b1;
        #1;
        n_cmp++;
        if (dout !== 32'h00000000) begin
            n_err++; $display("FAIL run0_status: got %h want %h", dout, 32'h00000000);
        end
        adr = 1'b0;
        ms = {1'b1, 3'b001, 2'b00, 10'd3, 2'b00, 10'd7};
        tick();
        tick();
        n_cmp++;
        if (dout !== 32'h89003007) begin
            n_err++; $display("FAIL run_rise_event: got %h want %h", dout, 32'h89003007);
        end
        adr = 1'b1;
        #1;
        n_cmp++;
        if (dout !== 32'h40000001) begin
            n_err++; $display("FAIL run_rise_count: got %h want %h", dout, 32'h40000001);
        end
        adr = 1'b0; rd = 1'b1;
        tick();
        rd = 1'b0;
    endtask

    task automatic test_order();
        logic [27:0] w [3];
        w[0] = 28'h8000101; w[1] = 28'h8000102; w[2] = 28'h8000103;
        for (int i = 0; i < 3; i++) begin
            ms = w[i];
            tick();
        end
        adr = 1'b1;
        #1;
        n_cmp++;
        if (dout !== 32'h40000003) begin
            n_err++; $display("FAIL order_count: got %h want %h", dout, 32'h40000003);
        end
        adr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rd = 1'b1;
            #1;
            n_cmp++;
            if (dout !== {4'b1000, w[i]}) begin
                n_err++; $display("FAIL order_pop%0d: got %h want %h", i, dout, {4'b1000, w[i]});
            end
            tick();
        end
        rd = 1'b1;
        #1;
        n_cmp++;
        if (dout !== 32'h08000103) begin
            n_err++; $display("FAIL underflow_read: got %h want %h", dout, 32'h08000103);
        end
        tick();
        rd = 1'b0; adr = 1'b1;
        #1;
        n_cmp++;
        if (dout !== 32'h40000000) begin
            n_err++; $display("FAIL underflow_count: got %h want %h", dout, 32'h40000000);
        end
        adr = 1'b0;
    endtask

    task automatic test_overflow();
        logic [27:0] expq [8];
        for (int i = 0; i < 10; i++) begin
            ms = 28'h8000201 + 28'(i);
            tick();
        end
        for (int i = 0; i < 7; i++) expq[i] = 28'h8000201 + 28'(i);
        expq[7] = 28'h800020A;
        adr = 1'b1; rd = 1'b1;
        #1;
        n_cmp++;
        if (dout !== 32'hC0000008) begin
            n_err++; $display("FAIL ovf_status: got %h want %h", dout, 32'hC0000008);
        end
        tick();
        adr = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rd = 1'b1;
            #1;
            n_cmp++;
            if (dout !== {4'b1000, expq[i]}) begin
                n_err++; $display("FAIL ovf_pop%0d: got %h want %h", i, dout, {4'b1000, expq[i]});
            end
            tick();
        end
        rd = 1'b0; adr = 1'b1;
        #1;
        n_cmp++;
        if (dout !== 32'h40000000) begin
            n_err++; $display("FAIL ovf_cleared: got %h want %h", dout, 32'h40000000);
        end
        adr = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [27:0] expq [8];
        for (int i = 0; i < 8; i++) begin
            ms = 28'h8000301 + 28'(i);
            tick();
        end
        adr = 1'b1;
        #1;
        n_cmp++;
        if (dout !== 32'h40000008) begin
            n_err++; $display("FAIL full_status: got %h want %h", dout, 32'h40000008);
        end
        // push and pop together on a full queue
        adr = 1'b0; rd = 1'b1; ms = 28'h8000309;
        #1;
        n_cmp++;
        if (dout !== 32'h88000301) begin
            n_err++; $display("FAIL full_pushpop_read: got %h want %h", dout, 32'h88000301);
        end
        tick();
        rd = 1'b0; adr = 1'b1;
        #1;
        n_cmp++;
        if (dout !== 32'h40000008) begin
            n_err++; $display("FAIL full_pushpop_status: got %h want %h", dout, 32'h40000008);
        end
        // status read coinciding with a coalescing overwrite
        rd = 1'b1; ms = 28'h800030A;
        tick();
        rd = 1'b0;
        #1;
        n_cmp++;
        if (dout !== 32'hC0000008) begin
            n_err++; $display("FAIL ovf_set_wins: got %h want %h", dout, 32'hC0000008);
        end
        adr = 1'b0;
        for (int i = 0; i < 7; i++) expq[i] = 28'h8000302 + 28'(i);
        expq[7] = 28'h800030A;
        for (int i = 0; i < 8; i++) begin
            rd = 1'b1;
            #1;
            n_cmp++;
            if (dout !== {4'b1000, expq[i]}) begin
                n_err++; $display("FAIL b2b_pop%0d: got %h want %h", i, dout, {4'b1000, expq[i]});
            end
            tick();
        end
        rd = 1'b0;
        adr = 1'b1; rd = 1'b1;
        tick();
        rd = 1'b0;
        #1;
        n_cmp++;
        if (dout !== 32'h40000000) begin
            n_err++; $display("FAIL b2b_final_status: got %h want %h", dout, 32'h40000000);
        end
        adr = 1'b0;
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 5; i++) begin
            ms = 28'h8000401 + 28'(i);
            tick();
        end
        adr = 1'b1;
        #1;
        n_cmp++;
        if (dout !== 32'h40000005) begin
            n_err++; $display("FAIL pre_reset_count: got %h want %h", dout, 32'h40000005);
        end
        #1;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (dout !== 32'h40000000) begin
            n_err++; $display("FAIL async_reset_count: got %h want %h", dout, 32'h40000000);
        end
        adr = 1'b0;
        #1;
        n_cmp++;
        if (dout !== 32'h08000405) begin
            n_err++; $display("FAIL async_reset_event: got %h want %h", dout, 32'h08000405);
        end
        tick();
        rst = 1'b0;
        tick();
        n_cmp++;
        if (dout !== 32'h88000405) begin
            n_err++; $display("FAIL post_reset_push: got %h want %h", dout, 32'h88000405);
        end
        tick();
        adr = 1'b1;
        #1;
        n_cmp++;
        if (dout !== 32'h40000001) begin
            n_err++; $display("FAIL post_reset_once: got %h want %h", dout, 32'h40000001);
        end
        adr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_run_gate();
        test_order();
        test_overflow();
        test_back_to_back();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
